// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   state_t          : fetch FSM states
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_INC           : byte distance between sequential instruction words
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_RSP = 2'd1,
        HOLD     = 2'd2,
        DISCARD  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_INC           = 4;

endpackage

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch controller.
// Issues one fetch at pc, waits for the word, holds it for decode until
// consumed, then advances pc by 4. A redirect from execute reloads pc (word
// aligned) from any state; a response belonging to a request that was in
// flight when the redirect arrived is swallowed in DISCARD.
//
// Ports:
//   clk, rst          clock (rising edge) / async active-high reset
//   imem_req_valid    fetch request, high only in FETCH
//   imem_req_ready    memory accepts the request
//   imem_addr         fetch address (= pc)
//   imem_rsp_valid    instruction word returned
//   imem_rsp_data     returned word
//   instr_valid       held instruction available to decode
//   instr, instr_pc   held instruction and its address
//   instr_ready       decode consumes the held instruction
//   redirect_valid    new target from execute
//   redirect_pc       redirect target (low two bits dropped)
//   misalign_err      one-cycle pulse after an unaligned redirect target
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             misalign_err
);

    state_t           state, state_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] redirect_aligned;
    logic             handshake;
    logic             capture;
    logic             consume;

    assign pc_inc           = pc + WIDTH'(PC_INC);  // wraps modulo 2^WIDTH
    assign redirect_aligned = {redirect_pc[WIDTH-1:2], 2'b00};
    assign handshake        = (state == FETCH) && imem_req_ready;
    // A redirect in the capture cycle drops the word: it belongs to the old path.
    assign capture          = (state == WAIT_RSP) && imem_rsp_valid && !redirect_valid;
    assign consume          = (state == HOLD) && instr_ready && !redirect_valid;

    assign imem_addr = pc;

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            FETCH: begin
                imem_req_valid = 1'b1;
                // A request accepted alongside a redirect still returns a
                // word, which must be thrown away.
                if (handshake) state_next = redirect_valid ? DISCARD : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (redirect_valid)      state_next = imem_rsp_valid ? FETCH : DISCARD;
                else if (imem_rsp_valid) state_next = HOLD;
            end
            HOLD: begin
                if (redirect_valid || instr_ready) state_next = FETCH;
            end
            DISCARD: begin
                if (imem_rsp_valid) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            instr_valid  <= 1'b0;
            instr        <= '0;
            instr_pc     <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);

            if (redirect_valid)  pc <= redirect_aligned;
            else if (consume)    pc <= pc_inc;

            if (capture) begin
                instr       <= imem_rsp_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if (redirect_valid || consume) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
